// File: rtl/jt12_wrq.sv
// jt12_wrq - CPU write queue for the JT12 register front end.
//
// Captures CPU address/data port writes at full clk rate. A data write is
// queued together with the part and register latched by the preceding address
// write. A small FSM replays queued writes to the register decoder as
// single-clk strobes, leaving BUSY_CYC cen_syn ticks between replays.
//
// Parameters:
//   DEPTH     FIFO entries (power of two, 2..64)
//   PARTS     register banks, 1..8 (PART_W = max(1, clog2(PARTS)))
//   BUSY_CYC  cen_syn ticks spent waiting after each replay, 1..255
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   cen_syn           synth clock enable, paces the replays
//   cpu_wr            CPU write strobe; a rising edge is one write
//   cpu_addr          [0]: 0 = address, 1 = data; [PART_W:1] = part
//   cpu_din           CPU data byte
//   ovf_clr           clears the sticky overflow flag
//   busy, full, ovf   status; level = number of queued entries
//   reg_wr            one-clk replay strobe
//   reg_part/sel/din  replayed write, held until the next strobe
//
// Optional feature (macro JT12_WRQ_COALESCE_EN): a data write to the same
// {part,sel} as the newest queued entry overwrites that entry's data.
//
// state    | meaning
// ST_IDLE  | ready to pop the head on the next cen_syn
// ST_WAIT  | counting BUSY_CYC cen_syn ticks after a replay
module jt12_wrq #(
  parameter int DEPTH    = 8,
  parameter int PARTS    = 2,
  parameter int BUSY_CYC = 32,
  localparam int PART_W  = (PARTS > 1) ? $clog2(PARTS) : 1,
  localparam int LVL_W   = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cen_syn,
  input  logic              cpu_wr,
  input  logic [PART_W:0]   cpu_addr,
  input  logic [7:0]        cpu_din,
  input  logic              ovf_clr,
  output logic              busy,
  output logic              full,
  output logic              ovf,
  output logic [LVL_W-1:0]  level,
  output logic              reg_wr,
  output logic [PART_W-1:0] reg_part,
  output logic [7:0]        reg_sel,
  output logic [7:0]        reg_din
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int ENT_W = PART_W + 16;

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t              state;
  logic [7:0]          cnt;
  logic                cpu_wr_d;
  logic [7:0]          sel_q;
  logic [PART_W-1:0]   part_q;
  logic [ENT_W-1:0]    mem [DEPTH];
  logic [PTR_W-1:0]    rd_ptr, wr_ptr, newest_ptr;
  logic                wr_acc, data_wr, pop, room, coal, push, drop;

  assign wr_acc     = cpu_wr & ~cpu_wr_d;
  assign data_wr    = wr_acc & cpu_addr[0];
  assign newest_ptr = wr_ptr - PTR_W'(1);
  assign pop        = (state == ST_IDLE) && (level != '0) && cen_syn;
  // A simultaneous pop frees a slot, so a full queue can still take the push.
  assign room       = (level != LVL_W'(DEPTH)) || pop;

`ifdef JT12_WRQ_COALESCE_EN
  // The newest entry is unavailable when it is also the head leaving this clk.
  assign coal = data_wr && (level != '0) && !(pop && level == LVL_W'(1)) &&
                (mem[newest_ptr][ENT_W-1:8] == {part_q, sel_q});
`else
  assign coal = 1'b0;
`endif

  assign push = data_wr & ~coal & room;
  assign drop = data_wr & ~coal & ~room;

  assign full = (level == LVL_W'(DEPTH));
  assign busy = (level != '0) || (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= {part_q, sel_q, cpu_din};
    else if (coal)
      mem[newest_ptr][7:0] <= cpu_din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_wr_d <= 1'b0;
      sel_q    <= '0;
      part_q   <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      ovf      <= 1'b0;
    end else begin
      cpu_wr_d <= cpu_wr;
      if (wr_acc && !cpu_addr[0]) begin
        sel_q  <= cpu_din;
        part_q <= cpu_addr[PART_W:1];
      end
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)
        level <= level + LVL_W'(1);
      else if (pop && !push)
        level <= level - LVL_W'(1);
      if (drop)
        ovf <= 1'b1;
      else if (ovf_clr)
        ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      reg_wr   <= 1'b0;
      reg_part <= '0;
      reg_sel  <= '0;
      reg_din  <= '0;
    end else begin
      reg_wr <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pop) begin
            {reg_part, reg_sel, reg_din} <= mem[rd_ptr];
            reg_wr <= 1'b1;
            cnt    <= '0;
            state  <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cen_syn) begin
            if (cnt == 8'(BUSY_CYC - 1))
              state <= ST_IDLE;
            else
              cnt <= cnt + 8'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jt12_wrq.sv
module tb_jt12_wrq;
  localparam int DEPTH    = 8;
  localparam int PARTS    = 4;
  localparam int BUSY_CYC = 5;
  localparam int PART_W   = (PARTS > 1) ? $clog2(PARTS) : 1;
  localparam int LVL_W    = $clog2(DEPTH) + 1;

  logic              clk = 0;
  logic              rst = 1;
  logic              cen_syn = 0;
  logic              cpu_wr = 0;
  logic [PART_W:0]   cpu_addr = '0;
  logic [7:0]        cpu_din = '0;
  logic              ovf_clr = 0;
  logic              busy, full, ovf, reg_wr;
  logic [LVL_W-1:0]  level;
  logic [PART_W-1:0] reg_part;
  logic [7:0]        reg_sel, reg_din;

  jt12_wrq #(.DEPTH(DEPTH), .PARTS(PARTS), .BUSY_CYC(BUSY_CYC)) dut (
    .clk(clk), .rst(rst), .cen_syn(cen_syn), .cpu_wr(cpu_wr),
    .cpu_addr(cpu_addr), .cpu_din(cpu_din), .ovf_clr(ovf_clr),
    .busy(busy), .full(full), .ovf(ovf), .level(level), .reg_wr(reg_wr),
    .reg_part(reg_part), .reg_sel(reg_sel), .reg_din(reg_din));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [PART_W-1:0] part;
    logic [7:0]        sel;
    logic [7:0]        din;
  } ent_t;

  // Reference model: the queue as a list of entries, pacing as "ticks left
  // before the next replay may start".
  ent_t              m_q[$];
  ent_t              exp_q[$];
  ent_t              m_last;
  ent_t              new_e;
  int                m_wait;
  logic              m_ovf;
  logic [7:0]        m_sel;
  logic [PART_W-1:0] m_part;
  logic              m_wr_d;
  int                n_before;
  bit                m_acc, m_pop, m_drop, m_coal;

  int  n_cmp = 0;
  int  n_err = 0;
  bit  checking = 0;
  int  cen_mode = 0;
  int  cyc = 0;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_q.delete(); exp_q.delete();
      m_wait = 0; m_ovf = 0; m_sel = 0; m_part = 0; m_wr_d = 0; m_last = '0;
    end else begin
      m_acc  = cpu_wr && !m_wr_d;
      m_wr_d = cpu_wr;
      n_before = m_q.size();
      m_pop  = (m_wait == 0) && cen_syn && (n_before > 0);
      if (m_pop) begin
        m_last = m_q.pop_front();
        exp_q.push_back(m_last);
        m_wait = BUSY_CYC;
      end else if (m_wait > 0 && cen_syn) begin
        m_wait--;
      end
      m_drop = 0;
      m_coal = 0;
      if (m_acc && cpu_addr[0]) begin
`ifdef JT12_WRQ_COALESCE_EN
        if (n_before > 0 && !(m_pop && n_before == 1) &&
            m_q[m_q.size()-1].part == m_part && m_q[m_q.size()-1].sel == m_sel) begin
          m_q[m_q.size()-1].din = cpu_din;
          m_coal = 1;
        end
`endif
        if (!m_coal) begin
          if (n_before < DEPTH || m_pop) begin
            new_e.part = m_part; new_e.sel = m_sel; new_e.din = cpu_din;
            m_q.push_back(new_e);
          end else begin
            m_drop = 1;
          end
        end
      end else if (m_acc) begin
        m_sel  = cpu_din;
        m_part = cpu_addr[PART_W:1];
      end
      if (m_drop) m_ovf = 1;
      else if (ovf_clr) m_ovf = 0;
    end
  end

  function automatic void chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // Monitor / scoreboard
  ent_t got;
  always @(negedge clk) begin
    if (checking) begin
      chk("level", int'(level), m_q.size());
      chk("full", int'(full), int'(m_q.size() == DEPTH));
      chk("busy", int'(busy), int'(m_q.size() != 0 || m_wait != 0));
      chk("ovf", int'(ovf), int'(m_ovf));
      if (reg_wr) begin
        got = '{reg_part, reg_sel, reg_din};
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL replay_unexpected: got part %0d sel %h din %h, none expected",
                   reg_part, reg_sel, reg_din);
        end else begin
          chk("replay", int'(got), int'(exp_q.pop_front()));
        end
      end else begin
        chk("replay_missing", 0, exp_q.size());
        exp_q.delete();
      end
      chk("held_entry", int'({reg_part, reg_sel, reg_din}), int'(m_last));
    end
  end

  always @(posedge clk) begin
    #2;
    case (cen_mode)
      0: cen_syn = 0;
      1: cen_syn = (cyc % 4 == 0);
      2: cen_syn = ($urandom_range(0, 2) == 0);
      3: cen_syn = 1;
      default: ;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic cpu_write(input logic [PART_W-1:0] p, input logic d, input logic [7:0] v);
    cpu_addr = {p, d};
    cpu_din  = v;
    cpu_wr   = 1;
    tick();
    cpu_wr = 0;
    tick();
  endtask

  task automatic drain();
    int i;
    cen_mode = 3;
    for (i = 0; i < 3000 && !(m_q.size() == 0 && m_wait == 0); i++) tick();
    n_cmp++;
    if (!(m_q.size() == 0 && m_wait == 0)) begin
      n_err++;
      $display("FAIL drain_timeout: got %0d queued expected 0", m_q.size());
    end
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1;
    tick(); tick();
    rst = 0;
    checking = 1;
    tick();

    // Single write, paced by a tick every 4 clk.
    cen_mode = 1;
    cpu_write(0, 0, 8'h28);
    cpu_write(0, 1, 8'hF0);
    drain();

    // Ten writes with no pacing ticks: overflow, then clear.
    cen_mode = 0;
    cpu_write(1, 0, 8'hA4);
    for (int i = 0; i < 10; i++) begin
      cpu_write(1, 0, 8'(8'hA4 + i));
      cpu_write(1, 1, 8'(i * 3 + 1));
    end
    ovf_clr = 1; tick(); ovf_clr = 0;
    drain();

    // Strobe held high: a single write.
    cen_mode = 0;
    cpu_addr = 2'b0 | {PART_W'(2), 1'b1};
    cpu_din = 8'h5A;
    cpu_wr = 1;
    repeat (20) tick();
    cpu_wr = 0;
    tick();
    drain();

    // Push into a full queue on the clk of a pop.
    cen_mode = 0;
    cpu_write(3, 0, 8'h30);
    for (int i = 0; i < DEPTH; i++) cpu_write(3, 1, 8'(i));
    cen_mode = 9;
    cpu_addr = {PART_W'(3), 1'b1}; cpu_din = 8'h77; cpu_wr = 1; cen_syn = 1;
    tick();
    cpu_wr = 0; cen_syn = 0;
    tick();
    drain();

    // Reset during the wait with entries still queued.
    cen_mode = 0;
    for (int i = 0; i < 4; i++) cpu_write(0, 1, 8'(8'h90 + i));
    cen_mode = 9; cen_syn = 1; tick(); cen_syn = 0; tick();
    rst = 1; tick(); rst = 0;
    cen_mode = 3;
    repeat (40) tick();

    // Two data writes to the same register while busy.
    cen_mode = 0;
    cpu_write(0, 0, 8'h20);
    cpu_write(0, 1, 8'h01);
    cen_mode = 9; cen_syn = 1; tick(); cen_syn = 0;
    cpu_write(0, 0, 8'h40);
    cpu_write(0, 1, 8'h11);
    cpu_write(0, 1, 8'h22);
    drain();

    // Randomized traffic.
    cen_mode = 2;
    for (int i = 0; i < 4000; i++) begin
      cpu_wr   = ($urandom_range(0, 1) == 1);
      cpu_addr = {PART_W'($urandom_range(0, PARTS - 1)), ($urandom_range(0, 3) != 0)};
      cpu_din  = 8'($urandom_range(0, 255));
      ovf_clr  = ($urandom_range(0, 19) == 0);
      rst      = ($urandom_range(0, 599) == 0);
      if (i % 1000 == 500) cen_mode = (cen_mode == 2) ? 0 : 2;
      tick();
    end
    cpu_wr = 0; ovf_clr = 0; rst = 0;
    tick();
    drain();

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
